// File: rtl/cache_refill_ctrl.sv
// AXI miss handler for the 2-way cache tag block: optional dirty-victim
// writeback burst, then a line refill (cached) or single-beat read (uncached).
module cache_refill_ctrl #(
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        miss,
  input  logic        cached,
  input  logic [31:0] axi_raddr,
  input  logic        write_back,
  input  logic [31:0] axi_waddr,
  input  logic [31:0] wb_rdata,
  output logic [3:0]  wb_word_idx,

  output logic        refill_we,
  output logic [3:0]  refill_word_idx,
  output logic [31:0] refill_wdata,
  output logic        refresh,
  output logic [31:0] uncached_rdata,
  output logic        busy,

  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,

  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rlast,

  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [3:0]  awid,

  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,

  input  logic        bvalid,
  output logic        bready
);

  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [3:0] LAST_IDX  = 4'(LINE_WORDS - 1);
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    WB_AW,
    WB_W,
    WB_B,
    RD_AR,
    RD_R,
    DONE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        cached_q;
  logic [31:0] raddr_q;
  logic [31:0] waddr_q;
  logic [3:0]  cnt;
  logic        guard;

  logic        launch;
  logic        last_beat;
  logic        w_fire;
  logic        r_fire;
  logic        clr_cnt;

  // guard suppresses a relaunch on the stale miss the tag block still holds
  // in the cycle right after the refresh pulse
  assign launch    = (state == IDLE) && miss && !guard;
  assign last_beat = (cnt == LAST_IDX);
  assign w_fire    = wvalid && wready;
  assign r_fire    = rready && rvalid;

  assign clr_cnt = ((next_state == WB_W) && (state != WB_W)) ||
                   ((next_state == RD_R) && (state != RD_R)) ||
                   (w_fire && last_beat);

  always_comb begin
    next_state = state;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    refill_we  = 1'b0;
    refresh    = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          next_state = (write_back && cached) ? WB_AW : RD_AR;
        end
      end
      WB_AW: begin
        awvalid = 1'b1;
        if (awready) next_state = WB_W;
      end
      WB_W: begin
        wvalid = 1'b1;
        if (wready && last_beat) next_state = WB_B;
      end
      WB_B: begin
        bready = 1'b1;
        if (bvalid) next_state = RD_AR;
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) next_state = RD_R;
      end
      RD_R: begin
        rready    = 1'b1;
        refill_we = rvalid && cached_q;
        if (rvalid && rlast) next_state = DONE;
      end
      DONE: begin
        refresh    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      guard <= 1'b0;
    end else begin
      state <= next_state;
      guard <= (state == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cached_q <= 1'b0;
      raddr_q  <= '0;
      waddr_q  <= '0;
    end else if (launch) begin
      cached_q <= cached;
      raddr_q  <= axi_raddr;
      waddr_q  <= axi_waddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (w_fire || r_fire) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uncached_rdata <= '0;
    end else if (r_fire && !cached_q) begin
      uncached_rdata <= rdata;
    end
  end

  assign busy            = (state != IDLE);

  assign araddr          = raddr_q;
  assign arlen           = cached_q ? BURST_LEN : 8'd0;
  assign arsize          = SIZE_WORD;
  assign arburst         = BURST_INCR;
  assign arid            = AXI_ID;

  assign awaddr          = waddr_q;
  assign awlen           = BURST_LEN;
  assign awsize          = SIZE_WORD;
  assign awburst         = BURST_INCR;
  assign awid            = AXI_ID;

  assign wb_word_idx     = cnt;
  assign wdata           = wb_rdata;
  assign wstrb           = 4'hf;
  assign wlast           = (state == WB_W) && last_beat;

  assign refill_word_idx = cnt;
  assign refill_wdata    = rdata;

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
AXI-side miss handler that sits directly downstream of the 2-way cache tag block. It consumes the tag block's miss/write_back/axi_raddr/axi_waddr outputs. It performs an optional 16-beat dirty-victim writeback, then a 16-beat line refill (cached) or a single-beat read (uncached). It streams refill words into cache data RAM and pulses refresh back to the tag block when the line is valid.

Parameters:
LINE_WORDS, 16, words per cache line (64-byte line, 6-bit offset); burst length is LINE_WORDS-1
AXI_ID, 4'd0, ID driven on arid/awid

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
miss  input  1  tag-block miss, level, held until refresh
cached  input  1  1 = cacheable line fill, 0 = uncached single word
axi_raddr  input  32  read address (line-aligned when cached)
write_back  input  1  victim valid, must be written back before refill
axi_waddr  input  32  victim line address, line-aligned
wb_rdata  input  32  victim word from cache data, combinational on wb_word_idx
wb_word_idx  output  4  victim word index being read
refill_we  output  1  write strobe into cache data
refill_word_idx  output  4  refill word index
refill_wdata  output  32  refill word
refresh  output  1  one-cycle pulse: line installed / uncached data ready
uncached_rdata  output  32  registered uncached read data, valid from refresh onward
busy  output  1  FSM not IDLE
arvalid/arready/araddr[32]/arlen[8]/arsize[3]/arburst[2]/arid[4]  AXI AR
rvalid/rready/rdata[32]/rlast[1]  AXI R
awvalid/awready/awaddr[32]/awlen[8]/awsize[3]/awburst[2]/awid[4]  AXI AW
wvalid/wready/wdata[32]/wstrb[4]/wlast[1]  AXI W
bvalid/bready  AXI B

Behaviour:
- Reset (rst=0, async): state IDLE. All valid/ready outputs, refill_we, refresh and busy are 0. Index counters are 0. uncached_rdata is 0.
- States: IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, DONE.
- IDLE: on miss=1, latch cached, axi_raddr and axi_waddr.
  - write_back=1 and cached=1 -> WB_AW. Otherwise -> RD_AR.
  - Inputs are sampled only in this cycle; later changes are ignored.
- WB_AW: awvalid=1, awaddr=latched waddr, awlen=LINE_WORDS-1, awsize=2, awburst=INCR (01). On awready -> WB_W.
- WB_W: wvalid=1, wdata=wb_rdata, wb_word_idx=beat counter, wstrb=4'hf, wlast=(counter==15).
  - Counter increments on wvalid&wready.
  - On the last handshake -> WB_B, counter cleared.
- WB_B: bready=1. On bvalid -> RD_AR.
- RD_AR: arvalid=1, araddr=latched raddr.
  - Cached: arlen=LINE_WORDS-1, arburst=INCR. Uncached: arlen=0.
  - arsize=2. On arready -> RD_R.
- RD_R: rready=1. On each rvalid beat:
  - Cached: refill_we=1 same cycle (combinational from rvalid&rready), refill_wdata=rdata, refill_word_idx=counter, counter++.
  - Uncached: refill_we stays 0; uncached_rdata registered.
  - On rlast -> DONE. If rlast never arrives, the FSM waits indefinitely; there is no timeout.
- DONE: refresh=1 for exactly one cycle, then -> IDLE.
  - The tag block deasserts miss the following cycle.
  - IDLE must not re-launch on miss in the cycle immediately after DONE (one-cycle guard), avoiding a double fill on the stale miss.
- All valid signals are held until handshake. Address/len do not change while valid=1.
- AW and AR are never outstanding simultaneously; writeback fully completes (B received) before AR issues, guaranteeing read-after-write ordering.
- Latency, zero-wait slave:
  - Cached miss with writeback: 1 AW + 16 W + 1 B + 1 AR + 16 R + 1 DONE = 36 cycles from leaving IDLE to the refresh pulse.
  - Cached miss without writeback: 18 cycles.
  - Uncached read: 3 cycles.
- write_back=1 with cached=0 is treated as no writeback.
- Pipeline flush while busy is ignored; AXI transactions are never aborted. The block completes and pulses refresh.
- Reset mid-transaction returns to IDLE immediately, and all valids drop asynchronously.
- Beat counter is 4 bits and wraps naturally 15->0. It is cleared on entering WB_W and RD_R.
- busy=1 in every state except IDLE.

Test Plan:
1. Cached miss, write_back=0, raddr=0x1fc0_0040, zero-wait slave -> arlen=15 and araddr=0x1fc0_0040; 16 refill_we pulses with idx 0..15 and data 0xA0..0xAF; refresh pulse 18 cycles after IDLE exit.
2. Cached miss, write_back=1, waddr=0x0000_1000, wb_rdata=0x100+idx -> AW before AR; 16 W beats with wdata 0x100..0x10F and wlast only on beat 15; arvalid never asserted before bvalid; refresh 36 cycles after start.
3. Uncached miss (cached=0), raddr=0xbfaf_8000, rdata=0xDEADBEEF -> arlen=0, no refill_we, uncached_rdata=0xDEADBEEF at refresh.
4. Slave backpressure: arready delayed 3 cycles, wready low on every other beat, rvalid gaps -> address/data stable while valid=1, word indices contiguous, no dropped or duplicated beats.
5. Reset asserted (rst=0) during RD_R beat 7 -> all valids and busy drop immediately; after release, a new miss restarts at RD_AR with counter 0.
6. miss held high through DONE and the following cycle -> exactly one AR per miss; no second transaction launched.
